// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU request arbiter slice.
//   - arb_state_t : arbiter sequencing states
//   - ST_*        : FPU core status codes (passed through unchanged)
//   - EXP_W, MANT_W, BIAS, FLT_W : custom float format (1 sign, 6 exp, 25 mant)
package fpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_OVF     = 4'b0011;
  localparam logic [3:0] ST_UNF     = 4'b0111;
  localparam logic [3:0] ST_INEXACT = 4'b1111;
  localparam logic [3:0] ST_TIMEOUT = 4'b0100;

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned MANT_W = 25;
  localparam int unsigned BIAS   = 31;
  localparam int unsigned FLT_W  = 1 + EXP_W + MANT_W;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search.
//   req       : request lines, one per requester
//   rr_ptr    : index with highest priority this round
//   grant_idx : first set bit of req at or above rr_ptr, wrapping modulo N_REQ
//   grant_vld : high when any request is set
module rr_picker
  import fpu_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_vld
);

  int unsigned     idx;
  logic [ID_W-1:0] sel;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      sel = ID_W'(idx);
      if (!grant_vld && req[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one custom-float FPU core among N_REQ requesters.
// One operation is outstanding at a time: IDLE picks a round-robin winner and
// latches its operands, ISSUE pulses fpu_start/req_ack, WAIT holds for
// fpu_done, RESP presents the result on a valid/ready port.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req, req_op_a/b       : per-requester request and packed 32-bit operands
//   req_ack               : one-cycle pulse to the granted requester
//   fpu_start, fpu_op_a/b : issue pulse and registered operands to the core
//   fpu_done/data/status  : core completion, result and status
//   resp_valid/ready      : response handshake
//   resp_data/status/id   : result, status and answered requester index
//   busy                  : high in every state except IDLE
//
// Optional feature: define FPU_REQ_ARB_TIMEOUT_EN to enable a WAIT watchdog
// that answers with resp_data=0 / ST_TIMEOUT after TIMEOUT_CYCLES.
module fpu_req_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*FLT_W-1:0] req_op_a,
  input  logic [N_REQ*FLT_W-1:0] req_op_b,
  output logic [N_REQ-1:0]       req_ack,
  output logic                   fpu_start,
  output logic [FLT_W-1:0]       fpu_op_a,
  output logic [FLT_W-1:0]       fpu_op_b,
  input  logic                   fpu_done,
  input  logic [FLT_W-1:0]       fpu_data,
  input  logic [3:0]             fpu_status,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [FLT_W-1:0]       resp_data,
  output logic [3:0]             resp_status,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] grant_idx;
  logic            grant_vld;

`ifdef FPU_REQ_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      req_ack     <= '0;
      fpu_start   <= 1'b0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= '0;
      resp_id     <= '0;
      busy        <= 1'b0;
`ifdef FPU_REQ_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      // Issue pulses are high only for the single ISSUE cycle.
      fpu_start <= 1'b0;
      req_ack   <= '0;
      unique case (state)
        S_IDLE: begin
          if (grant_vld) begin
            fpu_op_a  <= req_op_a[32'(grant_idx) * FLT_W +: FLT_W];
            fpu_op_b  <= req_op_b[32'(grant_idx) * FLT_W +: FLT_W];
            cur_id    <= grant_idx;
            fpu_start <= 1'b1;
            req_ack   <= N_REQ'(1) << grant_idx;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef FPU_REQ_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (fpu_done) begin
            resp_data   <= fpu_data;
            resp_status <= fpu_status;
            resp_id     <= cur_id;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end
`ifdef FPU_REQ_ARB_TIMEOUT_EN
          // Fires at the end of the TIMEOUT_CYCLES-th WAIT cycle; a done in
          // that same cycle takes the branch above instead.
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            resp_data   <= '0;
            resp_status <= ST_TIMEOUT;
            resp_id     <= cur_id;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
module tb_fpu_req_arbiter;
  import fpu_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned TMO = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*32-1:0]  req_op_a;
  logic [N*32-1:0]  req_op_b;
  logic [N-1:0]     req_ack;
  logic             fpu_start;
  logic [31:0]      fpu_op_a;
  logic [31:0]      fpu_op_b;
  logic             fpu_done;
  logic [31:0]      fpu_data;
  logic [3:0]       fpu_status;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [3:0]       resp_status;
  logic [IDW-1:0]   resp_id;
  logic             busy;

  always #5 clock = ~clock;

  fpu_req_arbiter #(
    .N_REQ          (N),
    .ID_W           (IDW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_op_a    (req_op_a),
    .req_op_b    (req_op_b),
    .req_ack     (req_ack),
    .fpu_start   (fpu_start),
    .fpu_op_a    (fpu_op_a),
    .fpu_op_b    (fpu_op_b),
    .fpu_done    (fpu_done),
    .fpu_data    (fpu_data),
    .fpu_status  (fpu_status),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_status (resp_status),
    .resp_id     (resp_id),
    .busy        (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Core model: done pulses core_lat cycles after the fpu_start cycle.
  bit          core_en    = 1'b1;
  int          core_lat   = 3;
  int          core_cnt   = 0;
  bit          core_fixed = 1'b0;
  logic [31:0] fix_data   = '0;
  logic [3:0]  fix_status = '0;
  int          done_cyc   = -100;
  logic [31:0] exp_data   = '0;
  logic [3:0]  exp_status = '0;
  logic [3:0]  codes [4]  = '{ST_EXACT, ST_OVF, ST_UNF, ST_INEXACT};

  // Requester-side reference state.
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  int          model_ptr = 0;
  int          last_id   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    cyc++;
    fpu_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        fpu_done   = 1'b1;
        fpu_data   = core_fixed ? fix_data : $urandom;
        fpu_status = core_fixed ? fix_status : codes[$urandom_range(0, 3)];
        exp_data   = fpu_data;
        exp_status = fpu_status;
        done_cyc   = cyc;
      end
    end
    if (fpu_start && core_en) core_cnt = core_lat;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < int'(N); k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic apply_ops();
    for (int i = 0; i < int'(N); i++) begin
      req_op_a[32*i +: 32] = op_a[i];
      req_op_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < int'(N); i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
    end
    apply_ops();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},    64'(req_ack),     64'(0));
    chk({tag, "_start"},  64'(fpu_start),   64'(0));
    chk({tag, "_opa"},    64'(fpu_op_a),    64'(0));
    chk({tag, "_opb"},    64'(fpu_op_b),    64'(0));
    chk({tag, "_valid"},  64'(resp_valid),  64'(0));
    chk({tag, "_data"},   64'(resp_data),   64'(0));
    chk({tag, "_status"}, 64'(resp_status), 64'(0));
    chk({tag, "_id"},     64'(resp_id),     64'(0));
    chk({tag, "_busy"},   64'(busy),        64'(0));
  endtask

  // One full transaction starting from an IDLE cycle.
  task automatic do_txn(input logic [N-1:0] mask, input int lat, input int bp,
                        input bit spurious, input bit hold);
    int w;
    logic [31:0] hd;
    logic [3:0]  hs;
    logic [1:0]  hi;
    core_lat = lat;
    req = mask;
    w = pick(mask, model_ptr);
    if (spurious) begin
      fpu_done = 1'b1; fpu_data = $urandom; fpu_status = ST_OVF; resp_ready = 1'b1;
    end
    cycle();
    chk("issue_start", 64'(fpu_start), 64'(1));
    chk("issue_ack",   64'(req_ack),   64'(N'(1) << w));
    chk("issue_opa",   64'(fpu_op_a),  64'(op_a[w]));
    chk("issue_opb",   64'(fpu_op_b),  64'(op_b[w]));
    chk("issue_busy",  64'(busy),      64'(1));
    if (!hold) req[w] = 1'b0;
    if (spurious) begin
      fpu_done = 1'b1; fpu_data = $urandom; fpu_status = ST_UNF;
    end
    cycle();
    resp_ready = 1'b0;
    chk("wait_quiet", 64'({fpu_start, req_ack}), 64'(0));
    for (int k = 0; k < 100 && !resp_valid; k++) cycle();
    chk("resp_valid",   64'(resp_valid),     64'(1));
    chk("resp_latency", 64'(cyc - done_cyc), 64'(1));
    chk("resp_data",    64'(resp_data),      64'(exp_data));
    chk("resp_status",  64'(resp_status),    64'(exp_status));
    chk("resp_id",      64'(resp_id),        64'(w));
    last_id = int'(resp_id);
    hd = resp_data; hs = resp_status; hi = resp_id;
    for (int k = 0; k < bp; k++) begin
      cycle();
      chk("bp_stable", 64'({resp_valid, resp_data, resp_status, resp_id}),
          64'({1'b1, hd, hs, hi}));
      chk("bp_no_issue", 64'({fpu_start, req_ack}), 64'(0));
    end
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    chk("post_valid", 64'(resp_valid), 64'(0));
    chk("post_busy",  64'(busy),       64'(0));
    model_ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    int t0;
    reset = 1'b1; req = '0; req_op_a = '0; req_op_b = '0;
    fpu_done = 1'b0; fpu_data = '0; fpu_status = '0; resp_ready = 1'b0;
    repeat (2) cycle();
    check_reset_vals("rst");
    reset = 1'b0;
    cycle();
    chk("idle_busy", 64'(busy), 64'(0));

    // Fairness: everyone holds req; order must be 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      load_ops();
      do_txn(4'b1111, 2, 0, 1'b0, 1'b1);
      chk("fair_order", 64'(last_id), 64'(k % 4));
    end

    // Single op from requester 2.
    load_ops();
    op_a[2] = 32'h3E000000; op_b[2] = 32'h3E000000;
    apply_ops();
    core_fixed = 1'b1; fix_data = 32'h40000000; fix_status = ST_EXACT;
    do_txn(4'b0100, 3, 0, 1'b0, 1'b0);
    chk("single_data", 64'(resp_data), 64'(32'h40000000));
    core_fixed = 1'b0;

    // Backpressure with another request pending.
    load_ops();
    do_txn(4'b0011, 2, 5, 1'b0, 1'b1);

    // Spurious done in IDLE and ISSUE, resp_ready outside RESP.
    load_ops();
    do_txn(4'b1000, 3, 1, 1'b1, 1'b0);

    // Reset during WAIT; the late done must be ignored.
    load_ops();
    req = 4'b0010;
    core_lat = 4;
    cycle();
    chk("rstw_start", 64'(fpu_start), 64'(1));
    req = '0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_vals("rstw");
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rstw_quiet", 64'({resp_valid, busy, fpu_start}), 64'(0));
    end
    model_ptr = 0;

    // Pointer wrap and lone requester at rr_ptr.
    load_ops();
    do_txn(4'b1000, 1, 0, 1'b0, 1'b0);
    load_ops();
    do_txn(4'b1001, 2, 0, 1'b0, 1'b0);
    chk("wrap_id", 64'(last_id), 64'(0));
    load_ops();
    do_txn(4'b0010, 1, 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      load_ops();
      do_txn(N'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef FPU_REQ_ARB_TIMEOUT_EN
    // Core never completes: response 9 cycles after fpu_start.
    core_en = 1'b0;
    load_ops();
    req = 4'b0100;
    w = pick(req, model_ptr);
    cycle();
    chk("tmo_start", 64'(fpu_start), 64'(1));
    t0 = cyc;
    req = '0;
    for (int k = 0; k < 50 && !resp_valid; k++) cycle();
    chk("tmo_latency", 64'(cyc - t0),     64'(9));
    chk("tmo_data",    64'(resp_data),    64'(0));
    chk("tmo_status",  64'(resp_status),  64'(ST_TIMEOUT));
    chk("tmo_id",      64'(resp_id),      64'(w));
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    chk("tmo_post", 64'(resp_valid), 64'(0));
    model_ptr = (w + 1) % N;
    core_en = 1'b1;
`else
    w = 0;
    t0 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
